// File: rtl/requant_shifter.sv
// requant_shifter: narrows a wide signed fixed-point value back to OUT_WIDTH bits.
// Stage 1 undoes the alignment shift (left shift into a widened word); stage 2
// rounds half-up, drops TAIL_BIT fraction bits and saturates. Clipped output
// transfers are counted in a sticky, clearable saturation counter.
module requant_shifter #(
  parameter int unsigned IN_WIDTH   = 15,
  parameter int unsigned IN_S_WIDTH = 3,
  parameter int unsigned OUT_WIDTH  = 10,
  parameter int unsigned TAIL_BIT   = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_WIDTH-1:0]   i_data,
  input  logic [IN_S_WIDTH-1:0] i_shift_value,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_sat,
  output logic [CNT_WIDTH-1:0]  o_sat_count,
  input  logic                  i_clear_count
);

  // Widened word holds the input shifted by the largest legal amount without overflow.
  localparam int unsigned WW = IN_WIDTH + (1 << IN_S_WIDTH);
  // One extra bit so the rounding increment can never overflow.
  localparam int unsigned RW = WW + 1;

  localparam logic signed [RW-1:0] RndInc =
      (TAIL_BIT == 0) ? '0 : (RW'(1) << ((TAIL_BIT == 0) ? 0 : TAIL_BIT - 1));
  localparam logic signed [RW-1:0] MaxPos = RW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MinNeg = ~MaxPos;
  localparam logic [OUT_WIDTH-1:0] OutMax = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OutMin = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic                  s1_en, s2_en;
  logic                  s1_valid_q, s1_valid_d;
  logic [WW-1:0]         s1_w_q, s1_w_d;
  logic [WW-1:0]         w_ext;
  logic                  o_valid_q, o_valid_d;
  logic [OUT_WIDTH-1:0]  o_data_q, o_data_d;
  logic                  o_sat_q, o_sat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic signed [RW-1:0]  r_sum, r_val;

  // Pipeline enables: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_en   = !o_valid_q || i_ready;
    s1_en   = !s1_valid_q || s2_en;
    o_ready = s1_en;
  end

  // Stage 1 next state: sign-extend and undo the alignment shift.
  always_comb begin
    w_ext      = {{(WW - IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
    s1_valid_d = s1_valid_q;
    s1_w_d     = s1_w_q;
    if (s1_en) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_w_d = w_ext << i_shift_value;
      end
    end
  end

  // Round half-up toward +infinity, then drop the fraction bits.
  always_comb begin
    r_sum = $signed({s1_w_q[WW-1], s1_w_q}) + RndInc;
    r_val = r_sum >>> TAIL_BIT;
  end

  // Stage 2 next state: saturate into the narrow range; hold under backpressure.
  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sat_d   = o_sat_q;
    if (s2_en) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (r_val > MaxPos) begin
          o_data_d = OutMax;
          o_sat_d  = 1'b1;
        end else if (r_val < MinNeg) begin
          o_data_d = OutMin;
          o_sat_d  = 1'b1;
        end else begin
          o_data_d = r_val[OUT_WIDTH-1:0];
          o_sat_d  = 1'b0;
        end
      end
    end
  end

  // Saturation counter: clear has priority, increments stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear_count) begin
      cnt_d = '0;
    end else if (o_valid_q && i_ready && o_sat_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset drops every in-flight beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_w_q     <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_sat_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_w_q     <= s1_w_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_sat_q    <= o_sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid     = o_valid_q;
  assign o_data      = o_data_q;
  assign o_sat       = o_sat_q;
  assign o_sat_count = cnt_q;

endmodule

// File: tb/tb_requant_shifter.sv
// Bench for requant_shifter: directed scenarios plus a randomized stream
// scored against an arithmetic reference model.
module tb_requant_shifter;
  localparam int IW = 15;
  localparam int SW = 3;
  localparam int OW = 10;
  localparam int TB = 5;
  localparam int CW = 16;
  localparam longint MAXP = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINN = -(longint'(1) << (OW - 1));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [IW-1:0] i_data = '0;
  logic [SW-1:0] i_shift = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [OW-1:0] o_data;
  logic          o_sat;
  logic [CW-1:0] o_sat_count;
  logic          i_clear = 1'b0;

  logic          s_ready, s_valid, s_sat;
  logic [OW-1:0] s_data;
  logic [1:0]    s_cnt;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;
  logic [OW:0] out_q[$];
  logic [OW:0] exp_q[$];

  always #5 clk = ~clk;

  requant_shifter #(
    .IN_WIDTH(IW), .IN_S_WIDTH(SW), .OUT_WIDTH(OW), .TAIL_BIT(TB), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_shift_value(i_shift), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sat(o_sat), .o_sat_count(o_sat_count), .i_clear_count(i_clear)
  );

  requant_shifter #(
    .IN_WIDTH(IW), .IN_S_WIDTH(SW), .OUT_WIDTH(OW), .TAIL_BIT(TB), .CNT_WIDTH(2)
  ) dut_small (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_data(i_data),
    .i_shift_value(i_shift), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data),
    .o_sat(s_sat), .o_sat_count(s_cnt), .i_clear_count(i_clear)
  );

  // Capture every output transfer ({sat, data}) away from the clock edge.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) out_q.push_back({o_sat, o_data});
  end

  // Reference: value * 2^shift / 2^TB rounded half-up (floor of x + 0.5), then clamped.
  function automatic logic [OW:0] model(input logic [IW-1:0] d, input int unsigned s);
    longint v, q, dv;
    logic [OW-1:0] lo;
    v = longint'($signed(d)) * (longint'(1) << s);
    if (TB > 0) begin
      dv = longint'(1) << TB;
      v  = v + dv / 2;
      q  = v / dv;
      if ((v % dv) != 0 && v < 0) q = q - 1;
    end else begin
      q = v;
    end
    if (q > MAXP) return {1'b1, OW'(MAXP)};
    if (q < MINN) return {1'b1, OW'(MINN)};
    lo = q[OW-1:0];
    return {1'b0, lo};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %b want 0", o_valid);
    else n_pass++;
    n_total++; if (o_data !== '0) $display("FAIL reset_o_data got %0d want 0", o_data);
    else n_pass++;
    n_total++; if (o_sat !== 1'b0) $display("FAIL reset_o_sat got %b want 0", o_sat);
    else n_pass++;
    n_total++; if (o_sat_count !== '0) $display("FAIL reset_count got %0d want 0", o_sat_count);
    else n_pass++;
    n_total++; if (o_ready !== 1'b1) $display("FAIL reset_o_ready got %b want 1", o_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_roundtrip();
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = IW'(-24); i_shift = 3'd2; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_total++; if (o_valid !== 1'b0) $display("FAIL rt_latency o_valid got %b want 0", o_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (o_valid !== 1'b1) $display("FAIL rt_o_valid got %b want 1", o_valid);
    else n_pass++;
    n_total++; if (o_data !== OW'(-3)) $display("FAIL rt_o_data got %0d want -3", $signed(o_data));
    else n_pass++;
    n_total++; if (o_sat !== 1'b0) $display("FAIL rt_o_sat got %b want 0", o_sat);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    int din[4] = '{16, 15, -16, -17};
    int dexp[4] = '{1, 0, 0, -1};
    logic want_v;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = IW'(din[0]); i_shift = '0; i_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      want_v = (i >= 2 && i <= 5);
      n_total++;
      if (o_valid !== want_v) $display("FAIL rnd_valid cyc %0d got %b want %b", i, o_valid, want_v);
      else n_pass++;
      if (want_v) begin
        n_total++;
        if (o_data !== OW'(dexp[i-2]) || o_sat !== 1'b0)
          $display("FAIL rnd_data beat %0d got %0d/%b want %0d/0", i - 2, $signed(o_data), o_sat,
                   dexp[i-2]);
        else n_pass++;
      end
      if (i < 4) i_data = IW'(din[i]);
      else i_valid = 1'b0;
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = IW'(16383); i_shift = 3'd7; i_ready = 1'b1;
    @(posedge clk); #1;
    i_data = IW'(-16384);
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_total++;
    if (o_valid !== 1'b1 || o_data !== OW'(511) || o_sat !== 1'b1)
      $display("FAIL sat_pos got %b/%0d/%b want 1/511/1", o_valid, $signed(o_data), o_sat);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (o_valid !== 1'b1 || o_data !== OW'(-512) || o_sat !== 1'b1)
      $display("FAIL sat_neg got %b/%0d/%b want 1/-512/1", o_valid, $signed(o_data), o_sat);
    else n_pass++;
    n_total++; if (o_sat_count !== CW'(1)) $display("FAIL sat_cnt1 got %0d want 1", o_sat_count);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (o_sat_count !== CW'(2)) $display("FAIL sat_cnt2 got %0d want 2", o_sat_count);
    else n_pass++;
    exp_cnt = 2;
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] bd[5];
    logic [SW-1:0] bs[5];
    int idx = 0, occ = 0, c = 0;
    bit held = 1'b0, saw_stall = 1'b0, acc, tx;
    logic [OW-1:0] prev_d;
    logic prev_s;
    out_q.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      bd[k] = IW'($urandom); bs[k] = SW'($urandom_range(0, 7));
      exp_q.push_back(model(bd[k], bs[k]));
    end
    while (out_q.size() < 5 && c < 60) begin
      @(posedge clk); #1;
      i_ready = !(c >= 3 && c <= 6);
      i_valid = (idx < 5);
      if (idx < 5) begin i_data = bd[idx]; i_shift = bs[idx]; end
      @(negedge clk);
      n_total++;
      if (o_ready !== ((occ < 2) || i_ready))
        $display("FAIL bp_o_ready cyc %0d got %b want %b", c, o_ready, (occ < 2) || i_ready);
      else n_pass++;
      if (held) begin
        n_total++;
        if (o_valid !== 1'b1 || o_data !== prev_d || o_sat !== prev_s)
          $display("FAIL bp_hold cyc %0d got %b/%0d/%b want 1/%0d/%b", c, o_valid, o_data, o_sat,
                   prev_d, prev_s);
        else n_pass++;
      end
      if (!o_ready) saw_stall = 1'b1;
      held = o_valid && !i_ready; prev_d = o_data; prev_s = o_sat;
      acc = i_valid && o_ready; tx = o_valid && i_ready;
      occ = occ + int'(acc) - int'(tx);
      if (acc) idx++;
      c++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_total++; if (saw_stall !== 1'b1) $display("FAIL bp_stall got %b want 1", saw_stall);
    else n_pass++;
    n_total++; if (out_q.size() != 5) $display("FAIL bp_count got %0d want 5", out_q.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < out_q.size(); k++) begin
      n_total++;
      if (out_q[k] !== exp_q[k]) $display("FAIL bp_beat %0d got %h want %h", k, out_q[k], exp_q[k]);
      else n_pass++;
      exp_cnt += int'(exp_q[k][OW]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_same_cycle();
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = IW'(16383); i_shift = 3'd7; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (o_valid !== 1'b1 || o_sat !== 1'b1 || o_sat_count !== CW'(exp_cnt))
      $display("FAIL clr_pre got %b/%b/%0d want 1/1/%0d", o_valid, o_sat, o_sat_count, exp_cnt);
    else n_pass++;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    n_total++; if (o_sat_count !== '0) $display("FAIL clr_count got %0d want 0", o_sat_count);
    else n_pass++;
    exp_cnt = 0;
  endtask

  task automatic test_count_saturate();
    @(posedge clk); #1;
    i_ready = 1'b1; i_valid = 1'b1; i_shift = 3'd7;
    for (int k = 0; k < 5; k++) begin
      i_data = (k % 2 == 0) ? IW'(16383) : IW'(-16384);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (o_sat_count !== CW'(5)) $display("FAIL cnt_wide got %0d want 5", o_sat_count);
    else n_pass++;
    n_total++; if (s_cnt !== 2'd3) $display("FAIL cnt_stick got %0d want 3", s_cnt);
    else n_pass++;
    exp_cnt = 5;
  endtask

  task automatic test_random();
    int acc = 0, cyc = 0;
    int ed[4] = '{16383, -16384, -1, 0};
    int es[4] = '{7, 0, 7, 0};
    out_q.delete(); exp_q.delete();
    while ((acc < 60 || out_q.size() < exp_q.size()) && cyc < 2000) begin
      @(posedge clk); #1;
      i_ready = ($urandom_range(0, 9) < 7);
      i_valid = (acc < 60) && ($urandom_range(0, 3) != 0);
      if (acc < 4) begin
        i_data = IW'(ed[acc]); i_shift = SW'(es[acc]);
      end else begin
        i_data = IW'($urandom); i_shift = SW'($urandom_range(0, 7));
      end
      @(negedge clk);
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_data, int'(i_shift)));
        acc++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    n_total++; if (cyc >= 2000) $display("FAIL rand_timeout got %0d cycles want <2000", cyc);
    else n_pass++;
    n_total++;
    if (out_q.size() != exp_q.size())
      $display("FAIL rand_count got %0d want %0d", out_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      exp_cnt += int'(exp_q[k][OW]);
      if (k < out_q.size()) begin
        n_total++;
        if (out_q[k] !== exp_q[k])
          $display("FAIL rand_beat %0d got %h want %h", k, out_q[k], exp_q[k]);
        else n_pass++;
      end
    end
    n_total++;
    if (o_sat_count !== CW'(exp_cnt))
      $display("FAIL rand_sat_count got %0d want %0d", o_sat_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    out_q.delete();
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b1; i_data = IW'(16383); i_shift = 3'd7;
    @(posedge clk); #1;
    i_data = IW'(-16384);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (o_valid !== 1'b1 || o_sat !== 1'b1 || o_sat_count !== CW'(exp_cnt))
      $display("FAIL ar_pre got %b/%b/%0d want 1/1/%0d", o_valid, o_sat, o_sat_count, exp_cnt);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_sat !== 1'b0 || o_sat_count !== '0)
      $display("FAIL ar_clear got %b/%0d/%b/%0d want 0/0/0/0", o_valid, o_data, o_sat,
               o_sat_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (o_valid !== 1'b0) $display("FAIL ar_stale cyc %0d got %b want 0", k, o_valid);
      else n_pass++;
    end
    n_total++; if (out_q.size() != 0) $display("FAIL ar_outq got %0d want 0", out_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_roundtrip();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_clear_same_cycle();
    test_count_saturate();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/requant_shifter.md
Name: requant_shifter

Overview:
- Narrowing counterpart of the input-alignment right shifter.
- Takes a wide signed fixed-point value carrying TAIL_BIT fraction bits and the shift value that produced it.
- Undoes the shift, rounds away the fraction bits and saturates to the narrow signed width.
- Sits at the accumulator/activation output of the NPU datapath as a 2-stage valid/ready pipeline; also counts saturation events for quantization debug.

Parameters:
- IN_WIDTH, 15: wide signed input width (fixed-point, TAIL_BIT fraction bits).
- IN_S_WIDTH, 3: shift-value width; maximum shift is 2^IN_S_WIDTH-1.
- OUT_WIDTH, 10: narrow signed output width.
- TAIL_BIT, 5: fraction bits removed by rounding; 0 allowed (no rounding).
- CNT_WIDTH, 16: saturation counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_data  input  IN_WIDTH  signed wide value.
- i_shift_value  input  IN_S_WIDTH  unsigned shift amount for this beat.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the beat.
- o_data  output  OUT_WIDTH  signed requantized value.
- o_sat  output  1  current o_data beat was clipped.
- o_sat_count  output  CNT_WIDTH  number of accepted clipped beats.
- i_clear_count  input  1  synchronous clear of o_sat_count.

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, o_valid=0, o_data=0, o_sat=0, o_sat_count=0.
  - Assertion mid-operation discards all in-flight beats; no output follows reset until new input arrives.
- Handshake:
  - A beat transfers in when i_valid && o_ready.
  - A beat transfers out when o_valid && i_ready.
  - Enables: s2_en = !o_valid || i_ready; s1_en = !s1_valid || s2_en; o_ready = s1_en.
  - o_ready never depends on i_valid.
  - o_data and o_sat are held stable while o_valid && !i_ready.
- Stage 1 (on s1_en):
  - Register s1_valid = i_valid.
  - When i_valid, also register W = i_data sign-extended to IN_WIDTH+2^IN_S_WIDTH bits, then shifted left by i_shift_value.
- Stage 2 (on s2_en):
  - o_valid <= s1_valid.
  - When s1_valid:
    - r = (W + 2^(TAIL_BIT-1)) >>> TAIL_BIT, computed one bit wider than W. This is round-half-up toward +infinity. If TAIL_BIT=0, r = W.
    - If r > 2^(OUT_WIDTH-1)-1: o_data = max positive, o_sat=1.
    - Else if r < -2^(OUT_WIDTH-1): o_data = min negative, o_sat=1.
    - Else o_data = r[OUT_WIDTH-1:0], o_sat=0.
- Latency and throughput:
  - Latency is 2 cycles from input acceptance to o_valid.
  - Throughput is 1 beat/cycle while i_ready=1.
  - Two beats are buffered under backpressure: o_ready drops in the cycle after the second beat lands with i_ready=0.
- Counter:
  - Increments by 1 on each output transfer with o_sat=1.
  - Sticks at all-ones and does not wrap.
  - i_clear_count sets it to 0 next edge; clear beats a same-cycle increment.
- Shift of 0 and maximum shift are both legal. The internal width guarantees no intermediate overflow for any input/shift pair.

Test Plan:
1. Round-trip with i_data=-24 (the aligner's output for input -3 with shift 2), i_shift_value=2 -> o_data=-3 two cycles later, o_sat=0.
2. Rounding at shift 0, back-to-back beats:
   - inputs 16, 15, -16, -17 -> outputs 1, 0, 0, -1.
   - o_valid continuous for 4 cycles after 2-cycle latency.
3. Saturation: i_data=16383, shift 7 -> o_data=511, o_sat=1. Then i_data=-16384, shift 7 -> o_data=-512, o_sat=1. o_sat_count=2 after both are accepted.
4. Backpressure:
   - Stream 5 beats with i_ready=0 from cycle 3 for 4 cycles.
   - o_ready low once two beats are held; o_data stable throughout.
   - On release, all 5 beats emerge in order, none lost or duplicated.
5. Counter control:
   - Assert i_clear_count in the same cycle as a clipped-beat transfer -> count becomes 0.
   - Force CNT_WIDTH=2 with 5 clipped beats -> count holds at 3.
6. Async reset mid-stream: assert i_rst between clock edges with 2 beats in flight -> o_valid, o_data, o_sat and the counter go to 0 immediately; no stale beat appears after release.
